// File: rtl/hd44780_sequencer.sv
// HD44780 4-bit write sequencer: power-up init, then byte writes
// as two enable strobes followed by the command execution wait.
module hd44780_sequencer #(
   parameter int unsigned SYSFREQ     = 48_000_000,
   parameter int unsigned E_SETUP_CYC = 2,
   parameter int unsigned E_HIGH_CYC  = 12,
   parameter int unsigned E_HOLD_CYC  = 2
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic [7:0] DAT_I,
   input  logic       RS_I,
   input  logic       STB_I,
   output logic       ready_o,
   output logic       init_done_o,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [3:0] lcd_data
);

   function automatic longint clamp1(input longint v);
      return (v < 64'sd1) ? 64'sd1 : v;
   endfunction

   function automatic longint mx(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   localparam longint F      = longint'(SYSFREQ);
   localparam longint T_PWR  = clamp1(F / 10);
   localparam longint T_4M1  = clamp1(F * 41 / 10000);
   localparam longint T_100U = clamp1(F / 10000);
   localparam longint T_3M   = clamp1(F * 3 / 1000);
   localparam longint T_53U  = clamp1(F * 53 / 1000000);
   localparam longint T_1U   = clamp1(F / 1000000);
   // ready rises where a fifth init strobe would have risen
   localparam longint T_LAST = T_100U + longint'(E_SETUP_CYC);

   localparam longint T_MAX = mx(mx(mx(T_PWR, T_4M1), mx(T_LAST, T_3M)),
                                 mx(longint'(E_HIGH_CYC), longint'(E_HOLD_CYC)));
   localparam int CW = $clog2(T_MAX + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t C_ONE   = cnt_t'(1);
   localparam cnt_t C_PWR   = cnt_t'(T_PWR);
   localparam cnt_t C_4M1   = cnt_t'(T_4M1);
   localparam cnt_t C_100U  = cnt_t'(T_100U);
   localparam cnt_t C_LAST  = cnt_t'(T_LAST);
   localparam cnt_t C_3M    = cnt_t'(T_3M);
   localparam cnt_t C_53U   = cnt_t'(T_53U);
   localparam cnt_t C_1U    = cnt_t'(T_1U);
   localparam cnt_t C_SETUP = cnt_t'(E_SETUP_CYC);
   localparam cnt_t C_HIGH  = cnt_t'(E_HIGH_CYC);
   localparam cnt_t C_HOLD  = cnt_t'(E_HOLD_CYC);

   typedef enum logic [2:0] {
      PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE,
      HI_NIB, GAP, LO_NIB, EXEC_WAIT
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP, PH_HIGH, PH_HOLD
   } phase_t;

   state_t     state;
   phase_t     ph;
   cnt_t       cnt;
   logic [1:0] step;
   logic [7:0] byte_q;
   logic       rs_q;
   logic       cnt_end;
   logic       ex_long;

   assign cnt_end = (cnt == C_ONE);
   // clear display / return home need the long execution time
   assign ex_long = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state       <= PWR_WAIT;
         ph          <= PH_SETUP;
         cnt         <= C_PWR;
         step        <= 2'd0;
         byte_q      <= 8'd0;
         rs_q        <= 1'b0;
         ready_o     <= 1'b0;
         init_done_o <= 1'b0;
         lcd_rs      <= 1'b0;
         lcd_e       <= 1'b0;
         lcd_data    <= 4'd0;
      end else begin
         unique case (state)
            PWR_WAIT: begin
               if (cnt_end) begin
                  state    <= INIT_NIB;
                  ph       <= PH_SETUP;
                  cnt      <= C_SETUP;
                  lcd_rs   <= 1'b0;
                  lcd_data <= 4'h3;
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
            INIT_NIB, HI_NIB, LO_NIB: begin
               if (!cnt_end) begin
                  cnt <= cnt - C_ONE;
               end else begin
                  unique case (ph)
                     PH_SETUP: begin
                        ph    <= PH_HIGH;
                        cnt   <= C_HIGH;
                        lcd_e <= 1'b1;
                     end
                     PH_HIGH: begin
                        ph    <= PH_HOLD;
                        cnt   <= C_HOLD;
                        lcd_e <= 1'b0;
                     end
                     default: begin
                        ph <= PH_SETUP;
                        unique case (state)
                           INIT_NIB: begin
                              state <= INIT_WAIT;
                              cnt   <= (step == 2'd0) ? C_4M1 :
                                       (step == 2'd3) ? C_LAST : C_100U;
                           end
                           HI_NIB: begin
                              state <= GAP;
                              cnt   <= C_1U;
                           end
                           default: begin
                              state <= EXEC_WAIT;
                              cnt   <= ex_long ? C_3M : C_53U;
                           end
                        endcase
                     end
                  endcase
               end
            end
            INIT_WAIT: begin
               if (!cnt_end) begin
                  cnt <= cnt - C_ONE;
               end else if (step == 2'd3) begin
                  state       <= IDLE;
                  ready_o     <= 1'b1;
                  init_done_o <= 1'b1;
               end else begin
                  state    <= INIT_NIB;
                  step     <= step + 2'd1;
                  cnt      <= C_SETUP;
                  lcd_data <= (step == 2'd2) ? 4'h2 : 4'h3;
               end
            end
            IDLE: begin
               if (STB_I) begin
                  state    <= HI_NIB;
                  ph       <= PH_SETUP;
                  cnt      <= C_SETUP;
                  byte_q   <= DAT_I;
                  rs_q     <= RS_I;
                  ready_o  <= 1'b0;
                  lcd_rs   <= RS_I;
                  lcd_data <= DAT_I[7:4];
               end
            end
            GAP: begin
               if (cnt_end) begin
                  state    <= LO_NIB;
                  cnt      <= C_SETUP;
                  lcd_data <= byte_q[3:0];
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
            EXEC_WAIT: begin
               if (cnt_end) begin
                  state   <= IDLE;
                  ready_o <= 1'b1;
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hd44780_sequencer.sv
// Directed bench for hd44780_sequencer at SYSFREQ=100 kHz:
// init timing, write latencies, ignored strobes, back-to-back, reset abort.
module tb_hd44780_sequencer;

   logic       CLK_I = 1'b0;
   logic       RST_I;
   logic [7:0] DAT_I;
   logic       RS_I;
   logic       STB_I;
   logic       ready_o;
   logic       init_done_o;
   logic       lcd_rs;
   logic       lcd_e;
   logic [3:0] lcd_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int rise_cyc[$];
   int rise_dat[$];
   int rise_rs[$];
   int hi_bad  = 0;
   int chg_bad = 0;
   int rstart  = 0;
   logic       pe = 1'b0;
   logic [3:0] pd;
   logic       pr;

   hd44780_sequencer #(.SYSFREQ(100_000)) dut (
      .CLK_I      (CLK_I),
      .RST_I      (RST_I),
      .DAT_I      (DAT_I),
      .RS_I       (RS_I),
      .STB_I      (STB_I),
      .ready_o    (ready_o),
      .init_done_o(init_done_o),
      .lcd_rs     (lcd_rs),
      .lcd_e      (lcd_e),
      .lcd_data   (lcd_data)
   );

   always #5 CLK_I = ~CLK_I;

   always @(posedge CLK_I) cyc <= cyc + 1;

   // enable pulse monitor, sampled just after each edge
   always @(posedge CLK_I) begin
      #1;
      if (lcd_e === 1'b1 && pe === 1'b0) begin
         rise_cyc.push_back(cyc);
         rise_dat.push_back(int'(lcd_data));
         rise_rs.push_back(int'(lcd_rs));
         rstart <= cyc;
      end
      if (lcd_e === 1'b0 && pe === 1'b1 && RST_I === 1'b1 && (cyc - rstart) != 12)
         hi_bad <= hi_bad + 1;
      if (RST_I === 1'b1 && (lcd_e === 1'b1 || pe === 1'b1) &&
          (lcd_data !== pd || lcd_rs !== pr))
         chg_bad <= chg_bad + 1;
      pe <= lcd_e;
      pd <= lcd_data;
      pr <= lcd_rs;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      rise_cyc.delete();
      rise_dat.delete();
      rise_rs.delete();
   endtask

   task automatic wait_ready(input int lim);
      int n;
      n = 0;
      while (ready_o !== 1'b1 && n < lim) begin
         @(negedge CLK_I);
         n++;
      end
   endtask

   task automatic write_byte(input logic [7:0] d, input logic rs, output int acc);
      DAT_I = d;
      RS_I  = rs;
      STB_I = 1'b1;
      @(negedge CLK_I);
      STB_I = 1'b0;
      acc   = cyc;
   endtask

   task automatic do_init(input string tag);
      int base;
      int er[4];
      int en[4];
      er = '{10002, 10428, 10454, 10480};
      en = '{3, 3, 3, 2};
      clear_q();
      base  = cyc;
      RST_I = 1'b1;
      wait_ready(12000);
      check({tag, "_ready_cyc"}, cyc - base, 10506);
      check({tag, "_done"}, init_done_o, 1);
      check({tag, "_npulse"}, rise_cyc.size(), 4);
      if (rise_cyc.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check({tag, "_rise"}, rise_cyc[i] - base, er[i]);
            check({tag, "_nib"}, rise_dat[i], en[i]);
            check({tag, "_rs"}, rise_rs[i], 0);
         end
      end
      repeat (20) @(negedge CLK_I);
      check({tag, "_ready_hold"}, ready_o, 1);
      check({tag, "_done_hold"}, init_done_o, 1);
   endtask

   task automatic byte_test(input logic [7:0] d, input logic rs, input int lat, input string tag);
      int acc;
      clear_q();
      write_byte(d, rs, acc);
      check({tag, "_busy"}, ready_o, 0);
      wait_ready(1000);
      check({tag, "_lat"}, cyc - acc, lat);
      check({tag, "_npulse"}, rise_cyc.size(), 2);
      if (rise_cyc.size() == 2) begin
         check({tag, "_rise0"}, rise_cyc[0] - acc, 2);
         check({tag, "_rise1"}, rise_cyc[1] - acc, 19);
         check({tag, "_hi"}, rise_dat[0], int'(d[7:4]));
         check({tag, "_lo"}, rise_dat[1], int'(d[3:0]));
         check({tag, "_rs0"}, rise_rs[0], int'(rs));
         check({tag, "_rs1"}, rise_rs[1], int'(rs));
      end
      @(negedge CLK_I);
   endtask

   initial begin
      int acc;
      int n;
      int k;
      int accs[3];
      logic prevr;

      RST_I = 1'b0;
      STB_I = 1'b0;
      DAT_I = 8'h00;
      RS_I  = 1'b0;
      repeat (3) @(negedge CLK_I);
      check("rst_e", lcd_e, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_data", lcd_data, 0);
      check("rst_ready", ready_o, 0);
      check("rst_done", init_done_o, 0);

      do_init("init");

      byte_test(8'h41, 1'b1, 38, "w41");
      byte_test(8'h01, 1'b0, 333, "clr");
      byte_test(8'h28, 1'b0, 38, "w28");
      byte_test(8'h00, 1'b0, 38, "w00");
      byte_test(8'h03, 1'b0, 333, "home");
      byte_test(8'h04, 1'b0, 38, "w04");
      byte_test(8'h01, 1'b1, 38, "d01");

      // strobe while busy must be dropped
      clear_q();
      write_byte(8'h81, 1'b1, acc);
      repeat (5) @(negedge CLK_I);
      DAT_I = 8'h55;
      RS_I  = 1'b0;
      STB_I = 1'b1;
      @(negedge CLK_I);
      STB_I = 1'b0;
      wait_ready(1000);
      check("ign_lat", cyc - acc, 38);
      check("ign_npulse", rise_cyc.size(), 2);
      if (rise_cyc.size() == 2) begin
         check("ign_hi", rise_dat[0], 8);
         check("ign_lo", rise_dat[1], 1);
         check("ign_rs", rise_rs[1], 1);
      end
      repeat (60) @(negedge CLK_I);
      check("ign_noqueue", rise_cyc.size(), 2);
      check("ign_ready", ready_o, 1);

      // back-to-back writes with STB_I held
      clear_q();
      DAT_I = 8'h30;
      RS_I  = 1'b1;
      STB_I = 1'b1;
      prevr = ready_o;
      k = 0;
      n = 0;
      while (k < 3 && n < 1000) begin
         @(negedge CLK_I);
         n++;
         if (prevr === 1'b1 && ready_o === 1'b0) begin
            accs[k] = cyc;
            k++;
            if (k == 3) STB_I = 1'b0;
         end
         prevr = ready_o;
      end
      STB_I = 1'b0;
      check("b2b_count", k, 3);
      wait_ready(1000);
      if (k == 3) begin
         check("b2b_gap1", accs[1] - accs[0], 39);
         check("b2b_gap2", accs[2] - accs[1], 39);
         check("b2b_last", cyc - accs[2], 38);
      end
      check("b2b_npulse", rise_cyc.size(), 6);
      @(negedge CLK_I);

      // reset during the low-nibble high phase
      clear_q();
      write_byte(8'h41, 1'b1, acc);
      n = 0;
      while (rise_cyc.size() < 2 && n < 200) begin
         @(negedge CLK_I);
         n++;
      end
      @(negedge CLK_I);
      check("abort_e_high", lcd_e, 1);
      RST_I = 1'b0;
      @(negedge CLK_I);
      check("abort_e", lcd_e, 0);
      check("abort_rs", lcd_rs, 0);
      check("abort_data", lcd_data, 0);
      check("abort_ready", ready_o, 0);
      check("abort_done", init_done_o, 0);
      repeat (3) @(negedge CLK_I);
      check("abort_npulse", rise_cyc.size(), 2);

      do_init("reinit");
      byte_test(8'h28, 1'b0, 38, "post");

      check("e_high_len", hi_bad, 0);
      check("bus_stable", chg_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
